// File: rtl/axi_rd_data_receiver.sv
// AXI read data channel receiver: checks one outstanding burst against its
// descriptor (id, length, response) and forwards beats through a small FIFO stream.
module axi_rd_data_receiver #(
    parameter int DATA_WIDTH   = 32,
    parameter int ID_MAX_WIDTH = 16,
    parameter int LEN_WIDTH    = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_cmd_valid,
    output logic                    o_cmd_ready,
    input  logic [ID_MAX_WIDTH-1:0] i_cmd_id,
    input  logic [LEN_WIDTH-1:0]    i_cmd_len,
    input  logic                    i_rvalid,
    output logic                    o_rready,
    input  logic [ID_MAX_WIDTH-1:0] i_rid,
    input  logic [DATA_WIDTH-1:0]   i_rdata,
    input  logic [1:0]              i_rresp,
    input  logic                    i_rlast,
    output logic                    o_out_valid,
    input  logic                    i_out_ready,
    output logic [DATA_WIDTH-1:0]   o_out_data,
    output logic                    o_out_last,
    output logic                    o_err_resp,
    output logic                    o_err_id,
    output logic                    o_err_len,
    output logic                    o_busy
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_DRAIN
    } state_t;

    state_t                  r_state;
    logic [ID_MAX_WIDTH-1:0] r_id;
    logic [LEN_WIDTH-1:0]    r_len;
    logic [LEN_WIDTH-1:0]    r_count;
    logic                    r_err_resp;
    logic                    r_err_id;
    logic                    r_err_len;

    logic [AW:0]             r_wr_ptr;
    logic [AW:0]             r_rd_ptr;
    logic [DATA_WIDTH:0]     r_mem [FIFO_DEPTH];

    logic                    w_full;
    logic                    w_empty;
    logic                    w_beat;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_at_len;
    logic                    w_last_flag;

    // Full when the index bits match but the wrap bits differ.
    assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                         (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_beat      = i_rvalid && o_rready;
    assign w_push      = w_beat && (r_state == S_RECV);
    assign w_pop       = o_out_valid && i_out_ready;
    assign w_at_len    = (r_count == r_len);
    assign w_last_flag = i_rlast || w_at_len;

    assign o_cmd_ready = (r_state == S_IDLE);
    assign o_rready    = ((r_state == S_RECV) && !w_full) || (r_state == S_DRAIN);
    assign o_out_valid = !w_empty;
    assign {o_out_data, o_out_last} = r_mem[r_rd_ptr[AW-1:0]];
    assign o_err_resp  = r_err_resp;
    assign o_err_id    = r_err_id;
    assign o_err_len   = r_err_len;
    assign o_busy      = (r_state != S_IDLE) || !w_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_id       <= '0;
            r_len      <= '0;
            r_count    <= '0;
            r_err_resp <= 1'b0;
            r_err_id   <= 1'b0;
            r_err_len  <= 1'b0;
        end else begin
            r_err_resp <= 1'b0;
            r_err_id   <= 1'b0;
            r_err_len  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_cmd_valid) begin
                        r_id    <= i_cmd_id;
                        r_len   <= i_cmd_len;
                        r_count <= '0;
                        r_state <= S_RECV;
                    end
                end
                S_RECV: begin
                    if (w_beat) begin
                        r_count    <= r_count + LEN_WIDTH'(1);
                        r_err_resp <= (i_rresp != 2'b00);
                        r_err_id   <= (i_rid != r_id);
                        // The counter never passes r_len here, so !w_at_len means early rlast.
                        if (i_rlast) begin
                            r_err_len <= !w_at_len;
                            r_state   <= S_IDLE;
                        end else if (w_at_len) begin
                            r_err_len <= 1'b1;
                            r_state   <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (i_rvalid && i_rlast) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= {i_rdata, w_last_flag};
                r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_axi_rd_data_receiver.sv
// Directed bench for axi_rd_data_receiver: a driver pushes expected stream beats
// into a queue, and a negedge monitor pops and compares them on every transfer.
module tb_axi_rd_data_receiver;

    logic        clk;
    logic        rstN;
    logic        cmdValid;
    logic        cmdReady;
    logic [15:0] cmdId;
    logic [7:0]  cmdLen;
    logic        rValid;
    logic        rReady;
    logic [15:0] rId;
    logic [31:0] rData;
    logic [1:0]  rResp;
    logic        rLast;
    logic        outValid;
    logic        outReady;
    logic [31:0] outData;
    logic        outLast;
    logic        errResp;
    logic        errId;
    logic        errLen;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic [32:0] expQ[$];
    logic        stallSeen;
    logic [32:0] stallData;

    axi_rd_data_receiver dut (
        .i_clk       (clk),
        .i_rst_n     (rstN),
        .i_cmd_valid (cmdValid),
        .o_cmd_ready (cmdReady),
        .i_cmd_id    (cmdId),
        .i_cmd_len   (cmdLen),
        .i_rvalid    (rValid),
        .o_rready    (rReady),
        .i_rid       (rId),
        .i_rdata     (rData),
        .i_rresp     (rResp),
        .i_rlast     (rLast),
        .o_out_valid (outValid),
        .i_out_ready (outReady),
        .o_out_data  (outData),
        .o_out_last  (outLast),
        .o_err_resp  (errResp),
        .o_err_id    (errId),
        .o_err_len   (errLen),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Stream monitor: every transfer must match the head of the expected queue,
    // and a stalled beat must hold its data until it is taken.
    always @(negedge clk) begin
        if (!rstN) begin
            stallSeen = 1'b0;
        end else begin
            if (stallSeen && outValid) begin
                checkOutput("stream_stable", {outData, outLast}, stallData);
            end
            if (outValid && outReady) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL stream_unexpected actual=0x%0h required=none", {outData, outLast});
                end else begin
                    checkOutput("stream_beat", {outData, outLast}, expQ.pop_front());
                end
                stallSeen = 1'b0;
            end else if (outValid) begin
                stallSeen = 1'b1;
                stallData = {outData, outLast};
            end else begin
                stallSeen = 1'b0;
            end
        end
    end

    task automatic sendCmd(input logic [15:0] id, input logic [7:0] len);
        bit got;
        got      = 1'b0;
        cmdValid = 1'b1;
        cmdId    = id;
        cmdLen   = len;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cmdReady) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("[TB] FAIL cmd_timeout actual=cmd_ready_low required=cmd_ready_high");
        end
        @(posedge clk);
        #1;
        cmdValid = 1'b0;
    endtask

    // Drives one R beat, waits for acceptance, then checks the error pulses
    // and cmd_ready in the following cycle.
    task automatic applyStimulus(input logic [15:0] id, input logic [31:0] data,
                                 input logic [1:0] resp, input logic last,
                                 input logic push, input logic expLast,
                                 input logic [2:0] expErr, input logic expCmdReady);
        bit got;
        got    = 1'b0;
        rValid = 1'b1;
        rId    = id;
        rData  = data;
        rResp  = resp;
        rLast  = last;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rReady) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("[TB] FAIL beat_timeout actual=rready_low required=rready_high data=0x%0h", data);
        end
        @(posedge clk);
        #1;
        rValid = 1'b0;
        if (push && got) expQ.push_back({data, expLast});
        @(negedge clk);
        checkOutput("err_flags", {errResp, errId, errLen}, expErr);
        checkOutput("cmd_ready_after_beat", cmdReady, expCmdReady);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rstN     = 1'b0;
        cmdValid = 1'b0;
        cmdId    = '0;
        cmdLen   = '0;
        rValid   = 1'b0;
        rId      = '0;
        rData    = '0;
        rResp    = '0;
        rLast    = 1'b0;
        outReady = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_cmd_ready", cmdReady, 1);
        checkOutput("rst_rready", rReady, 0);
        checkOutput("rst_out_valid", outValid, 0);
        checkOutput("rst_errs", {errResp, errId, errLen}, 0);
        checkOutput("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rstN = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] normal burst");
        sendCmd(16'd3, 8'd3);
        applyStimulus(16'd3, 32'hA0, 2'b00, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
        applyStimulus(16'd3, 32'hA1, 2'b00, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
        applyStimulus(16'd3, 32'hA2, 2'b00, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
        applyStimulus(16'd3, 32'hA3, 2'b00, 1'b1, 1'b1, 1'b1, 3'b000, 1'b1);

        $display("[TB] backpressure");
        outReady = 1'b0;
        sendCmd(16'd3, 8'd5);
        applyStimulus(16'd3, 32'hB0, 2'b00, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
        applyStimulus(16'd3, 32'hB1, 2'b00, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
        applyStimulus(16'd3, 32'hB2, 2'b00, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
        applyStimulus(16'd3, 32'hB3, 2'b00, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("bp_rready_full", rReady, 0);
        checkOutput("bp_out_valid", outValid, 1);
        checkOutput("bp_busy", busy, 1);
        @(posedge clk);
        #1;
        outReady = 1'b1;
        applyStimulus(16'd3, 32'hB4, 2'b00, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
        applyStimulus(16'd3, 32'hB5, 2'b00, 1'b1, 1'b1, 1'b1, 3'b000, 1'b1);

        $display("[TB] early rlast");
        sendCmd(16'd2, 8'd3);
        applyStimulus(16'd2, 32'hC0, 2'b00, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
        applyStimulus(16'd2, 32'hC1, 2'b00, 1'b1, 1'b1, 1'b1, 3'b001, 1'b1);

        $display("[TB] late rlast");
        sendCmd(16'd4, 8'd1);
        applyStimulus(16'd4, 32'hD0, 2'b00, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
        applyStimulus(16'd4, 32'hD1, 2'b00, 1'b0, 1'b1, 1'b1, 3'b001, 1'b0);
        @(negedge clk);
        checkOutput("drain_rready", rReady, 1);
        @(posedge clk);
        #1;
        applyStimulus(16'd4, 32'hD2, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
        applyStimulus(16'd4, 32'hD3, 2'b10, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1);

        $display("[TB] error flags");
        sendCmd(16'd5, 8'd0);
        applyStimulus(16'd6, 32'hE0, 2'b10, 1'b1, 1'b1, 1'b1, 3'b110, 1'b1);

        $display("[TB] reset mid-burst");
        outReady = 1'b0;
        sendCmd(16'd7, 8'd3);
        applyStimulus(16'd7, 32'hF0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
        applyStimulus(16'd7, 32'hF1, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
        rstN = 1'b0;
        expQ.delete();
        #2;
        checkOutput("midrst_out_valid", outValid, 0);
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("postrst_out_valid", outValid, 0);
        checkOutput("postrst_rready", rReady, 0);
        checkOutput("postrst_cmd_ready", cmdReady, 1);
        @(posedge clk);
        #1;
        outReady = 1'b1;
        sendCmd(16'd1, 8'd1);
        applyStimulus(16'd1, 32'h11, 2'b00, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
        applyStimulus(16'd1, 32'h12, 2'b00, 1'b1, 1'b1, 1'b1, 3'b000, 1'b1);

        $display("[TB] max length burst");
        sendCmd(16'd9, 8'd255);
        for (int i = 0; i < 256; i++) begin
            applyStimulus(16'd9, 32'h1000 + i, 2'b00, (i == 255), 1'b1, (i == 255),
                          3'b000, (i == 255));
        end

        begin
            bit drained;
            drained = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (expQ.size() == 0 && !busy) begin
                    drained = 1'b1;
                    break;
                end
            end
            checkOutput("final_drained", drained, 1);
            checkOutput("final_queue_left", expQ.size(), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_rd_data_receiver.md
Name: axi_rd_data_receiver

Overview:
Master-side consumer of the AXI read data channel. It accepts R beats for one outstanding burst at a time and checks rid, rresp and beat count against a command from the read address issuer. Beats pass through a small FIFO to a valid/ready stream feeding the CNN feature/weight loaders.

Parameters:
DATA_WIDTH, 32, width of rdata and out_data
ID_MAX_WIDTH, 16, width of rid and cmd_id
LEN_WIDTH, 8, width of cmd_len (AXI4 len encoding: beats-1)
FIFO_DEPTH, 4, output buffer entries; power of 2, minimum 2

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  burst descriptor valid
cmd_ready  out  1  descriptor accepted when cmd_valid && cmd_ready
cmd_id  in  ID_MAX_WIDTH  expected rid for the burst
cmd_len  in  LEN_WIDTH  expected beats minus 1
rvalid  in  1  R channel valid
rready  out  1  R channel ready
rid  in  ID_MAX_WIDTH  R channel id
rdata  in  DATA_WIDTH  R channel data
rresp  in  2  R channel response
rlast  in  1  R channel last
out_valid  out  1  stream valid
out_ready  in  1  stream ready
out_data  out  DATA_WIDTH  stream data
out_last  out  1  final beat of burst on stream
err_resp  out  1  one-cycle pulse: accepted beat had rresp != 2'b00
err_id  out  1  one-cycle pulse: accepted beat rid != latched cmd_id
err_len  out  1  one-cycle pulse: burst length mismatch
busy  out  1  state != IDLE or FIFO non-empty

Behaviour:
- Reset, async assert and sync-free deassert: state=IDLE, FIFO empty, beat counter 0, latched id/len 0. All outputs 0 except cmd_ready=1 (IDLE).
- Beat accept: a beat is accepted when rvalid && rready. Stream transfer: out_valid && out_ready.
- States:
  - IDLE: cmd_ready=1, rready=0. On cmd handshake, latch cmd_id/cmd_len, clear counter, go RECV.
  - RECV: cmd_ready=0, rready = !fifo_full. No bypass: a full FIFO blocks R even if a pop occurs the same cycle.
    - Each accepted beat pushes {rdata, last_flag} and increments the counter.
    - last_flag = rlast || (counter == latched_len).
    - Accepted beat with rlast=1 and counter == len: normal end, go IDLE.
    - Accepted beat with rlast=1 and counter < len: early end. Pulse err_len, push with last_flag=1, go IDLE.
    - Accepted beat with rlast=0 and counter == len: late rlast. Pulse err_len, push with last_flag=1, go DRAIN.
  - DRAIN: cmd_ready=0, rready=1 unconditionally. Accepted beats are discarded (not pushed, no error checks). Accepted beat with rlast=1 goes IDLE.
- Checks on every beat accepted in RECV:
  - err_resp pulses the cycle after acceptance if rresp != 0. Data is still forwarded.
  - err_id pulses the cycle after acceptance on rid mismatch. Data is still forwarded.
  - err_len also pulses the cycle after the offending beat.
  - All three error outputs are registered and may pulse in the same cycle.
- Latency: a beat accepted in cycle N is visible on out_valid/out_data/out_last in cycle N+1 if the FIFO was empty. Registered read side; out_data is stable while out_valid && !out_ready.
- FIFO:
  - Pointers are log2(FIFO_DEPTH)+1 bits with wrap bit; full/empty come from pointer compare.
  - Simultaneous push and pop when non-full and non-empty keeps occupancy unchanged.
  - out_valid = !empty.
- A new cmd may be accepted in IDLE while the FIFO still drains. Stream order is preserved across bursts.
- Counter width is LEN_WIDTH; cmd_len=255 yields 256 beats with no overflow before the compare.
- Reset mid-burst clears the FIFO and state immediately. Beats the interconnect still sends are not accepted, because rready=0 in IDLE.

Test Plan:
- Normal burst: cmd_id=3, cmd_len=3; 4 beats 0xA0..0xA3, rid=3, rlast on 4th, out_ready=1. -> Stream shows A0..A3 with out_last on A3 only, 1-cycle latency, no error pulses, returns to IDLE.
- Backpressure: same burst with out_ready=0 for 10 cycles. -> rready drops after 4 beats (FIFO full). After out_ready=1, data is emitted in order, no beat lost or duplicated.
- Early rlast: cmd_len=3, rlast on 2nd beat. -> err_len pulse one cycle after beat 2, out_last on beat 2, cmd_ready=1 next cycle.
- Late rlast: cmd_len=1, rlast on 4th beat. -> out_last on beat 2, err_len pulse, beats 3-4 accepted and dropped (rready=1), then IDLE.
- Error flags: cmd_id=5, beat 1 with rid=6 and rresp=2'b10. -> err_id and err_resp pulse the same cycle, data still appears on stream.
- Reset mid-burst: assert rst_n=0 after 2 of 4 beats. -> out_valid=0, rready=0, cmd_ready=1 after release. A following fresh burst passes cleanly.
